// File: rtl/fft_mag_streamer_pkg.sv
// Shared widths, magnitude sentinels and FSM encoding for fft_mag_streamer.
package fft_mag_streamer_pkg;

  localparam int BIN_IDX_W = 9;
  localparam int MAG_W     = 32;

  localparam logic signed [MAG_W-1:0] MAG_IDLE = 32'sh80000000;
  localparam logic signed [MAG_W-1:0] MAG_MAX  = 32'sh7FFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/fft_mag_streamer_mag_sq_pipe.sv
// Two-stage re^2 + im^2 datapath with saturation; valid/bin tag travel alongside.
module mag_sq_pipe
  import fft_mag_streamer_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [BIN_IDX_W-1:0]        in_tag,
  input  logic signed [DATA_W-1:0]    in_re,
  input  logic signed [DATA_W-1:0]    in_im,
  output logic                        out_valid,
  output logic                        out_start,
  output logic [BIN_IDX_W-1:0]        out_tag,
  output logic signed [MAG_W-1:0]     out_mag
);

  localparam int SQ_W  = 2 * DATA_W;
  localparam int SUM_W = SQ_W + 1;
  localparam int CMP_W = (SUM_W > MAG_W) ? SUM_W : MAG_W + 1;

  logic                     sq_valid;
  logic [BIN_IDX_W-1:0]     sq_tag;
  logic signed [SQ_W-1:0]   sq_re;
  logic signed [SQ_W-1:0]   sq_im;
  logic [SUM_W-1:0]         sum;
  logic [CMP_W-1:0]         sum_ext;
  logic signed [MAG_W-1:0]  sat_mag;

  // Square stage: both squares are non-negative and fit in 2*DATA_W signed bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_valid <= 1'b0;
      sq_tag   <= '0;
      sq_re    <= '0;
      sq_im    <= '0;
    end else begin
      sq_valid <= in_valid;
      sq_tag   <= in_tag;
      sq_re    <= SQ_W'(in_re) * SQ_W'(in_re);
      sq_im    <= SQ_W'(in_im) * SQ_W'(in_im);
    end
  end

  // Unsigned sum clamped to the largest positive magnitude; only (-max,-max) reaches 2^31.
  always_comb begin
    sum     = SUM_W'(unsigned'(sq_re)) + SUM_W'(unsigned'(sq_im));
    sum_ext = CMP_W'(sum);
    if (sum_ext > CMP_W'(unsigned'(MAG_MAX))) begin
      sat_mag = MAG_MAX;
    end else begin
      sat_mag = signed'(MAG_W'(sum_ext));
    end
  end

  // Output stage: idle cycles carry the most negative value so the consumer never updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_tag   <= '0;
      out_mag   <= MAG_IDLE;
    end else begin
      out_valid <= sq_valid;
      out_start <= sq_valid && (sq_tag == '0);
      out_tag   <= sq_tag;
      out_mag   <= sq_valid ? sat_mag : MAG_IDLE;
    end
  end

endmodule

// File: rtl/fft_mag_streamer.sv
// Reads a finished FFT frame bin by bin and streams squared magnitudes to the peak finder.
module fft_mag_streamer
  import fft_mag_streamer_pkg::*;
#(
  parameter int NUM_BINS = 512,
  parameter int DATA_W   = 16,
  parameter int DC_ZERO  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_ready,
  output logic [8:0]               ram_addr,
  output logic                     ram_en,
  input  logic signed [DATA_W-1:0] ram_re,
  input  logic signed [DATA_W-1:0] ram_im,
  output logic                     start,
  output logic signed [31:0]       data_out,
  output logic [8:0]               index,
  output logic                     valid,
  output logic                     done,
  output logic                     busy,
  output logic                     overrun
);

  localparam logic [BIN_IDX_W-1:0] LAST_BIN = BIN_IDX_W'(NUM_BINS - 1);

  state_t                   state;
  logic                     rd_valid;
  logic [BIN_IDX_W-1:0]     rd_tag;
  logic                     s1_valid;
  logic [BIN_IDX_W-1:0]     s1_tag;
  logic signed [DATA_W-1:0] s1_re;
  logic signed [DATA_W-1:0] s1_im;
  logic                     p_valid;
  logic                     p_start;
  logic [BIN_IDX_W-1:0]     p_tag;
  logic signed [MAG_W-1:0]  p_mag;

  // Scan sequencer: issue addresses, wait for the last bin to leave the pipe, pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ram_addr <= '0;
      ram_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= frame_ready && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (frame_ready) begin
            state    <= ST_READ;
            ram_addr <= '0;
            ram_en   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_READ: begin
          if (ram_addr == LAST_BIN) begin
            state    <= ST_DRAIN;
            ram_en   <= 1'b0;
            ram_addr <= '0;
          end else begin
            ram_addr <= ram_addr + BIN_IDX_W'(1);
          end
        end
        ST_DRAIN: begin
          if (p_valid && (p_tag == LAST_BIN)) begin
            state <= ST_FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Tag delayed to RAM-output time, then the RAM data captured with its tag (DC bin zeroed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_tag   <= '0;
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_re    <= '0;
      s1_im    <= '0;
    end else begin
      rd_valid <= ram_en;
      rd_tag   <= ram_addr;
      s1_valid <= rd_valid;
      s1_tag   <= rd_tag;
      if ((DC_ZERO != 0) && (rd_tag == '0)) begin
        s1_re <= '0;
        s1_im <= '0;
      end else begin
        s1_re <= ram_re;
        s1_im <= ram_im;
      end
    end
  end

  mag_sq_pipe #(
    .DATA_W (DATA_W)
  ) u_mag_sq_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_tag    (s1_tag),
    .in_re     (s1_re),
    .in_im     (s1_im),
    .out_valid (p_valid),
    .out_start (p_start),
    .out_tag   (p_tag),
    .out_mag   (p_mag)
  );

  assign start    = p_start;
  assign valid    = p_valid;
  assign index    = p_tag;
  assign data_out = p_mag;

endmodule

// File: tb/tb_fft_mag_streamer.sv
// Directed bench for fft_mag_streamer with an 8-bin frame and a tiny peak-tracking consumer.
module tb_fft_mag_streamer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               frame_ready;
  logic [8:0]         ram_addr;
  logic               ram_en;
  logic signed [15:0] ram_re = '0;
  logic signed [15:0] ram_im = '0;
  logic               start;
  logic signed [31:0] data_out;
  logic [8:0]         index;
  logic               valid;
  logic               done;
  logic               busy;
  logic               overrun;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] re_mem [0:511];
  logic signed [15:0] im_mem [0:511];
  logic signed [31:0] exp_mag [0:7];

  logic signed [31:0] pk  = '0;
  logic [8:0]         pki = '0;

  fft_mag_streamer #(
    .NUM_BINS (8),
    .DATA_W   (16),
    .DC_ZERO  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_ready (frame_ready),
    .ram_addr    (ram_addr),
    .ram_en      (ram_en),
    .ram_re      (ram_re),
    .ram_im      (ram_im),
    .start       (start),
    .data_out    (data_out),
    .index       (index),
    .valid       (valid),
    .done        (done),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data valid one cycle after ram_en/ram_addr.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_re <= re_mem[ram_addr];
      ram_im <= im_mem[ram_addr];
    end
  end

  // Peak-finder stand-in: restart on start, keep strictly larger valid magnitudes.
  always @(posedge clk) begin
    if (start) begin
      pk  <= data_out;
      pki <= index;
    end else if (valid && (data_out > pk)) begin
      pk  <= data_out;
      pki <= index;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_addr", {23'd0, ram_addr}, 32'd0);
    chk("rst_index", {23'd0, index}, 32'd0);
    chk("rst_data_out", data_out, 32'h80000000);
  endtask

  task automatic fill(input logic signed [15:0] re, input logic signed [15:0] im);
    for (int i = 0; i < 8; i++) begin
      re_mem[i] = re;
      im_mem[i] = im;
    end
  endtask

  // frame_ready sampled at edge k; iteration c checks the state just after edge k+c.
  task automatic scan(input int ovr_at);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    chk("issue_busy", {31'd0, busy}, 32'd1);
    chk("issue_ram_en", {31'd0, ram_en}, 32'd1);
    chk("issue_ram_addr", {23'd0, ram_addr}, 32'd0);
    for (int c = 1; c <= 13; c++) begin
      if (c == ovr_at) frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      chk($sformatf("overrun_c%0d", c), {31'd0, overrun}, {31'd0, (c == ovr_at)});
      chk($sformatf("done_c%0d", c), {31'd0, done}, {31'd0, (c == 12)});
      chk($sformatf("busy_c%0d", c), {31'd0, busy}, {31'd0, (c < 12)});
      if (c >= 4 && c <= 11) begin
        chk($sformatf("valid_c%0d", c), {31'd0, valid}, 32'd1);
        chk($sformatf("start_c%0d", c), {31'd0, start}, {31'd0, (c == 4)});
        chk($sformatf("index_c%0d", c), {23'd0, index}, 32'(c - 4));
        chk($sformatf("data_c%0d", c), data_out, exp_mag[c-4]);
      end else begin
        chk($sformatf("valid_c%0d", c), {31'd0, valid}, 32'd0);
        chk($sformatf("idle_data_c%0d", c), data_out, 32'h80000000);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_ready = 1'b0;
    fill(16'sd0, 16'sd0);
    step();
    step();
    chk_reset_vals();
    rst_n = 1'b1;
    step();

    // Frame A: bin 3 = (3,4), others (1,0).
    fill(16'sd1, 16'sd0);
    re_mem[3] = 16'sd3;
    im_mem[3] = 16'sd4;
    exp_mag = '{32'sd0, 32'sd1, 32'sd1, 32'sd25, 32'sd1, 32'sd1, 32'sd1, 32'sd1};
    scan(0);
    chk("peak_a", {23'd0, pki}, 32'd3);

    // Idle gap between frames.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("gap_valid", {31'd0, valid}, 32'd0);
      chk("gap_data", data_out, 32'h80000000);
    end
    chk("gap_peak", {23'd0, pki}, 32'd3);

    // Same frame, extra frame_ready three cycles into the scan.
    scan(3);
    chk("peak_a_ovr", {23'd0, pki}, 32'd3);

    // Saturation frame, plus frame_ready landing in the FINISH cycle.
    fill(16'sd1, 16'sd0);
    re_mem[5] = -16'sd32768;
    im_mem[5] = -16'sd32768;
    re_mem[6] = 16'sd32767;
    im_mem[6] = -16'sd32768;
    exp_mag = '{32'sd0, 32'sd1, 32'sd1, 32'sd1, 32'sd1, 32'sd2147483647, 32'sd2147418113, 32'sd1};
    scan(13);
    step();
    chk("no_restart_busy", {31'd0, busy}, 32'd0);
    chk("no_restart_ram_en", {31'd0, ram_en}, 32'd0);
    chk("peak_sat", {23'd0, pki}, 32'd5);

    // Reset asserted mid-READ.
    fill(16'sd1, 16'sd0);
    re_mem[3] = 16'sd3;
    im_mem[3] = 16'sd4;
    exp_mag = '{32'sd0, 32'sd1, 32'sd1, 32'sd25, 32'sd1, 32'sd1, 32'sd1, 32'sd1};
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    step();
    step();
    chk("midscan_ram_en", {31'd0, ram_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_done", {31'd0, done}, 32'd0);
      chk("post_rst_valid", {31'd0, valid}, 32'd0);
    end
    scan(0);
    chk("peak_after_rst", {23'd0, pki}, 32'd3);

    // Back-to-back frames: B peaks at bin 2, C at bin 6.
    fill(16'sd1, 16'sd1);
    re_mem[2] = 16'sd10;
    im_mem[2] = 16'sd0;
    exp_mag = '{32'sd0, 32'sd2, 32'sd100, 32'sd2, 32'sd2, 32'sd2, 32'sd2, 32'sd2};
    scan(0);
    chk("peak_b", {23'd0, pki}, 32'd2);
    fill(16'sd2, -16'sd1);
    re_mem[6] = -16'sd20;
    im_mem[6] = 16'sd15;
    exp_mag = '{32'sd0, 32'sd5, 32'sd5, 32'sd5, 32'sd5, 32'sd5, 32'sd625, 32'sd5};
    scan(0);
    chk("peak_c", {23'd0, pki}, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
